// File: rtl/apb4_master_pkg.sv
// Shared types and constants for the APB4 initiator bridge.
package apb4_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   localparam logic [2:0] PROT_NORMAL = 3'b000;
   localparam logic [2:0] PROT_PRIV   = 3'b001;

   // Byte-strobe width for a given data bus width.
   function automatic int unsigned APB4_STRB_W(input int unsigned data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/apb4_tmo_cnt.sv
// Saturating ACCESS-phase wait counter; done_c flags the cycle that reaches LIMIT.
module apb4_tmo_cnt #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic done_c
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;
   localparam logic [WIDTH-1:0] LIM_M1  = (LIMIT == 0) ? '0 : WIDTH'(LIMIT - 1);

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != CNT_MAX)) begin
         cnt <= cnt + WIDTH'(1);
      end
   end

   // The cycle whose missing pready would make the LIMIT-th wait cycle; LIMIT=0 never fires.
   assign done_c = (LIMIT != 0) && en && (cnt == LIM_M1);

endmodule

// File: rtl/apb4_master_bridge.sv
// APB4 initiator: one valid/ready request in, one SETUP/ACCESS transfer out, one response back.
module apb4_master_bridge
   import apb4_master_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TMO_WIDTH  = 8,
   parameter int unsigned TMO_CYCLES = 255
) (
   input  logic                                 pclk,
   input  logic                                 presetn,
   input  logic                                 req_valid_i,
   output logic                                 req_ready_o,
   input  logic [ADDR_WIDTH-1:0]                req_addr_i,
   input  logic                                 req_write_i,
   input  logic [DATA_WIDTH-1:0]                req_wdata_i,
   input  logic [APB4_STRB_W(DATA_WIDTH)-1:0]   req_wstrb_i,
   input  logic [2:0]                           req_prot_i,
   output logic                                 rsp_valid_o,
   input  logic                                 rsp_ready_i,
   output logic [DATA_WIDTH-1:0]                rsp_rdata_o,
   output logic                                 rsp_err_o,
   output logic                                 rsp_tmo_o,
   output logic [ADDR_WIDTH-1:0]                paddr_o,
   output logic                                 psel_o,
   output logic                                 penable_o,
   output logic                                 pwrite_o,
   output logic [DATA_WIDTH-1:0]                pwdata_o,
   output logic [APB4_STRB_W(DATA_WIDTH)-1:0]   pstrb_o,
   output logic [2:0]                           pprot_o,
   input  logic [DATA_WIDTH-1:0]                prdata_i,
   input  logic                                 pready_i,
   input  logic                                 pslverr_i
);

   state_e state;
   logic   tmo_en;
   logic   tmo_clr;
   logic   tmo_done;

   assign tmo_en  = (state == ST_ACCESS) && !pready_i;
   assign tmo_clr = (state != ST_ACCESS);

   apb4_tmo_cnt #(
      .WIDTH (TMO_WIDTH),
      .LIMIT (TMO_CYCLES)
   ) u_tmo_cnt (
      .clk    (pclk),
      .rst_n  (presetn),
      .en     (tmo_en),
      .clr    (tmo_clr),
      .done_c (tmo_done)
   );

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state       <= ST_IDLE;
         req_ready_o <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_rdata_o <= '0;
         rsp_err_o   <= 1'b0;
         rsp_tmo_o   <= 1'b0;
         paddr_o     <= '0;
         psel_o      <= 1'b0;
         penable_o   <= 1'b0;
         pwrite_o    <= 1'b0;
         pwdata_o    <= '0;
         pstrb_o     <= '0;
         pprot_o     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               req_ready_o <= 1'b1;
               if (req_valid_i && req_ready_o) begin
                  // Reads drive zero data/strobes; the latched fields stay put until ACCESS ends.
                  req_ready_o <= 1'b0;
                  paddr_o     <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
                  pwrite_o    <= req_write_i;
                  pwdata_o    <= req_write_i ? req_wdata_i : '0;
                  pstrb_o     <= req_write_i ? req_wstrb_i : '0;
                  pprot_o     <= req_prot_i;
                  psel_o      <= 1'b1;
                  state       <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               penable_o <= 1'b1;
               state     <= ST_ACCESS;
            end
            ST_ACCESS: begin
               // pready takes priority over a timeout landing on the same cycle.
               if (pready_i) begin
                  psel_o      <= 1'b0;
                  penable_o   <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
                  rsp_err_o   <= pslverr_i;
                  rsp_tmo_o   <= 1'b0;
                  state       <= ST_RESP;
               end else if (tmo_done) begin
                  psel_o      <= 1'b0;
                  penable_o   <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  rsp_rdata_o <= '0;
                  rsp_err_o   <= 1'b1;
                  rsp_tmo_o   <= 1'b1;
                  state       <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  req_ready_o <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Randomised bench for apb4_master_bridge: slave/timing expectations come from a transfer-level model.
module tb_apb4_master_bridge;

   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned SW  = DW / 8;
   localparam int unsigned TMO = 4;

   logic          pclk = 1'b0;
   logic          presetn;
   logic          req_valid;
   logic          req_ready;
   logic [AW-1:0] req_addr;
   logic          req_write;
   logic [DW-1:0] req_wdata;
   logic [SW-1:0] req_wstrb;
   logic [2:0]    req_prot;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          rsp_tmo;
   logic [AW-1:0] paddr;
   logic          psel;
   logic          penable;
   logic          pwrite;
   logic [DW-1:0] pwdata;
   logic [SW-1:0] pstrb;
   logic [2:0]    pprot;
   logic [DW-1:0] prdata;
   logic          pready;
   logic          pslverr;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 pclk = ~pclk;

   apb4_master_bridge #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .TMO_WIDTH  (8),
      .TMO_CYCLES (TMO)
   ) dut (
      .pclk        (pclk),
      .presetn     (presetn),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_addr_i  (req_addr),
      .req_write_i (req_write),
      .req_wdata_i (req_wdata),
      .req_wstrb_i (req_wstrb),
      .req_prot_i  (req_prot),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_rdata_o (rsp_rdata),
      .rsp_err_o   (rsp_err),
      .rsp_tmo_o   (rsp_tmo),
      .paddr_o     (paddr),
      .psel_o      (psel),
      .penable_o   (penable),
      .pwrite_o    (pwrite),
      .pwdata_o    (pwdata),
      .pstrb_o     (pstrb),
      .pprot_o     (pprot),
      .prdata_i    (prdata),
      .pready_i    (pready),
      .pslverr_i   (pslverr)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      @(negedge pclk);
   endtask

   // One complete transfer; called and returns on a falling edge with the bridge idle.
   task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [2:0] prot, input int waits,
                       input logic serr, input logic [31:0] rdata, input int hold);
      int          budget;
      int          nacc;
      bit          to;
      logic [31:0] e_paddr;
      logic [31:0] e_pwdata;
      logic [3:0]  e_pstrb;
      logic [31:0] e_rdata;
      logic        e_err;
      budget = 0;
      while (!req_ready && budget < 20) begin
         tick();
         budget++;
      end
      check("req_ready_idle", 64'(req_ready), 64'd1);

      req_valid = 1'b1;
      req_addr  = addr;
      req_write = wr;
      req_wdata = wdata;
      req_wstrb = strb;
      req_prot  = prot;
      tick();
      // Scramble request inputs to prove the bridge latched them.
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_write = 1'($urandom);
      req_wdata = $urandom;
      req_wstrb = 4'($urandom);
      req_prot  = 3'($urandom);

      to       = (TMO != 0) && (waits >= int'(TMO));
      nacc     = to ? int'(TMO) : waits + 1;
      e_paddr  = addr & 32'hFFFF_FFFC;
      e_pwdata = wr ? wdata : 32'h0;
      e_pstrb  = wr ? strb : 4'h0;
      e_rdata  = (wr || to) ? 32'h0 : rdata;
      e_err    = to || serr;

      check("setup_ctl", 64'({psel, penable, req_ready, rsp_valid}), 64'(4'b1000));
      check("setup_addr", 64'(paddr), 64'(e_paddr));
      check("setup_data", 64'({pwrite, pwdata, pstrb, pprot}), 64'({wr, e_pwdata, e_pstrb, prot}));
      pready  = 1'($urandom);
      pslverr = 1'($urandom);
      prdata  = $urandom;
      tick();

      for (int k = 0; k < nacc; k++) begin
         check("access_ctl", 64'({psel, penable, req_ready, rsp_valid}), 64'(4'b1100));
         check("access_hold", 64'({pwrite, pwdata, pstrb, pprot, paddr}),
               64'({wr, e_pwdata, e_pstrb, prot, e_paddr}));
         if (k == waits) begin
            pready  = 1'b1;
            pslverr = serr;
            prdata  = rdata;
         end else begin
            pready  = 1'b0;
            pslverr = 1'($urandom);
            prdata  = $urandom;
         end
         tick();
      end
      pready  = 1'b0;
      pslverr = 1'b0;

      for (int h = 0; h <= hold; h++) begin
         pready = 1'($urandom);
         check("rsp_ctl", 64'({rsp_valid, psel, penable, req_ready}), 64'(4'b1000));
         check("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
         check("rsp_err_tmo", 64'({rsp_err, rsp_tmo}), 64'({e_err, to}));
         rsp_ready = (h == hold);
         tick();
      end
      rsp_ready = 1'b0;
      pready    = 1'b0;
      check("rsp_done", 64'({rsp_valid, req_ready}), 64'(2'b01));
   endtask

   initial begin
      presetn   = 1'b0;
      req_valid = 1'b0;
      req_addr  = '0;
      req_write = 1'b0;
      req_wdata = '0;
      req_wstrb = '0;
      req_prot  = '0;
      rsp_ready = 1'b0;
      prdata    = '0;
      pready    = 1'b0;
      pslverr   = 1'b0;
      repeat (3) tick();
      check("reset_ctl", 64'({req_ready, rsp_valid, rsp_err, rsp_tmo, psel, penable, pwrite, pstrb, pprot}), 64'd0);
      check("reset_bus", 64'(paddr | pwdata | rsp_rdata), 64'd0);
      presetn = 1'b1;
      tick();

      // Directed cases.
      xfer(32'h0000_0004, 1'b1, 32'h5A5A_0001, 4'hF, 3'b000, 0, 1'b0, 32'h0, 0);
      xfer(32'h0000_0008, 1'b0, 32'h0, 4'h0, 3'b001, 3, 1'b0, 32'h0000_0001, 0);
      xfer(32'h0000_0020, 1'b0, 32'h0, 4'h0, 3'b010, 0, 1'b1, 32'hDEAD_BEEF, 0);
      xfer(32'h0000_0030, 1'b0, 32'h0, 4'h0, 3'b000, 10, 1'b0, 32'h1234_5678, 0);
      xfer(32'h0000_0034, 1'b1, 32'hCAFE_F00D, 4'h5, 3'b000, 4, 1'b0, 32'h0, 1);
      xfer(32'h0000_0040, 1'b1, 32'h0BAD_0001, 4'h3, 3'b001, 1, 1'b0, 32'h0, 5);
      xfer(32'h0000_0013, 1'b0, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'h0000_0077, 0);

      // Reset while in ACCESS: bus drops on the next edge and no response follows.
      req_valid = 1'b1;
      req_addr  = 32'h0000_0050;
      req_write = 1'b0;
      tick();
      req_valid = 1'b0;
      tick();
      check("pre_rst_access", 64'({psel, penable}), 64'(2'b11));
      presetn = 1'b0;
      tick();
      check("midrst_ctl", 64'({req_ready, rsp_valid, rsp_err, rsp_tmo, psel, penable, pwrite, pstrb, pprot}), 64'd0);
      check("midrst_bus", 64'(paddr | pwdata | rsp_rdata), 64'd0);
      presetn = 1'b1;
      pready  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("post_rst_quiet", 64'({rsp_valid, psel, penable}), 64'd0);
      end
      pready = 1'b0;

      // Randomised transfers.
      for (int n = 0; n < 40; n++) begin
         xfer($urandom, 1'($urandom), $urandom, 4'($urandom), 3'($urandom),
              int'($urandom_range(0, 6)), 1'($urandom_range(0, 3) == 0), $urandom,
              int'($urandom_range(0, 2)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
